// File: rtl/inference_sequencer_pkg.sv
// Shared configuration for the inference sequencer: data/address widths,
// default frame geometry and the FSM state encoding.
package inference_sequencer_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int PIX_AW         = 10;
    localparam int HID_AW         = 7;
    localparam int NUM_PIXELS_DEF = 784;
    localparam int NUM_HIDDEN_DEF = 128;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_L1_FEED  = 3'd2;
    localparam logic [2:0] ST_L1_DRAIN = 3'd3;
    localparam logic [2:0] ST_L2_FEED  = 3'd4;
    localparam logic [2:0] ST_L2_DRAIN = 3'd5;
    localparam logic [2:0] ST_RESULT   = 3'd6;

endpackage

// File: rtl/inference_sequencer_seq_counter.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag
// that compares against a run-time terminal value.
module seq_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Count up while enabled; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/inference_sequencer.sv
// Frame sequencer for a two-layer inference accelerator: clears the
// accelerator, streams one frame of pixels into layer 1, sweeps the hidden
// features through layer 2 and presents the argmax digit with a handshake.
module inference_sequencer
    import inference_sequencer_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int NUM_HIDDEN = NUM_HIDDEN_DEF,
    parameter int L1_DRAIN   = 2,
    parameter int L2_DRAIN   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    input  logic                  s_pixel_valid,
    input  logic [DATA_WIDTH-1:0] s_pixel_data,
    output logic                  s_pixel_ready,
    output logic                  acc_clr,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic [PIX_AW-1:0]     l1_addr,
    output logic [HID_AW-1:0]     l2_addr,
    output logic                  l2_en,
    input  logic [3:0]            digit_in,
    output logic                  result_valid,
    output logic [3:0]            result_digit,
    input  logic                  result_ready
);

    localparam int DRN_MAX = (L1_DRAIN > L2_DRAIN) ? L1_DRAIN : L2_DRAIN;
    localparam int DRN_W   = $clog2(DRN_MAX + 1);

    logic [2:0]        state, state_nxt;
    logic              accept;
    logic [PIX_AW-1:0] pix_cnt;
    logic              pix_tc;
    logic [HID_AW-1:0] feat_cnt;
    logic              feat_tc;
    logic [DRN_W-1:0]  drn_cnt, drn_last;
    logic              drn_tc;
    logic              in_drain;

    // s_pixel_ready is a registered copy of (state == ST_L1_FEED)
    assign accept   = s_pixel_valid && s_pixel_ready;
    assign in_drain = (state == ST_L1_DRAIN) || (state == ST_L2_DRAIN);
    assign drn_last = (state == ST_L1_DRAIN) ? DRN_W'(L1_DRAIN - 1) : DRN_W'(L2_DRAIN - 1);

    // Each counter is held at zero outside its own state, so it restarts on entry
    seq_counter #(.W(PIX_AW)) u_pix_cnt (
        .clk(clk), .rst(rst), .clr(state != ST_L1_FEED), .en(accept),
        .last(PIX_AW'(NUM_PIXELS - 1)), .cnt(pix_cnt), .tc(pix_tc)
    );

    seq_counter #(.W(HID_AW)) u_feat_cnt (
        .clk(clk), .rst(rst), .clr(state != ST_L2_FEED), .en(state == ST_L2_FEED),
        .last(HID_AW'(NUM_HIDDEN - 1)), .cnt(feat_cnt), .tc(feat_tc)
    );

    // One drain counter serves both drain phases; they are never adjacent
    seq_counter #(.W(DRN_W)) u_drn_cnt (
        .clk(clk), .rst(rst), .clr(!in_drain), .en(in_drain),
        .last(drn_last), .cnt(drn_cnt), .tc(drn_tc)
    );

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start)            state_nxt = ST_CLEAR;
            ST_CLEAR:                          state_nxt = ST_L1_FEED;
            ST_L1_FEED:  if (accept && pix_tc) state_nxt = ST_L1_DRAIN;
            ST_L1_DRAIN: if (drn_tc)           state_nxt = ST_L2_FEED;
            ST_L2_FEED:  if (feat_tc)          state_nxt = ST_L2_DRAIN;
            ST_L2_DRAIN: if (drn_tc)           state_nxt = ST_RESULT;
            ST_RESULT:   if (result_ready)     state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    // State register and registered outputs, decoded from the next state so
    // every output changes on the same edge as the state itself
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            s_pixel_ready <= 1'b0;
            acc_clr       <= 1'b0;
            pixel_out     <= '0;
            l1_addr       <= '0;
            l2_addr       <= '0;
            l2_en         <= 1'b0;
            result_valid  <= 1'b0;
            result_digit  <= '0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != ST_IDLE);
            s_pixel_ready <= (state_nxt == ST_L1_FEED);
            acc_clr       <= (state_nxt == ST_CLEAR);
            l2_en         <= (state_nxt == ST_L2_FEED) || (state_nxt == ST_L2_DRAIN) ||
                             (state_nxt == ST_RESULT);
            result_valid  <= (state_nxt == ST_RESULT);

            if (accept) begin
                pixel_out <= s_pixel_data;
                l1_addr   <= pix_cnt;
            end else begin
                pixel_out <= '0;
            end

            // l2_addr leads feat_cnt by one so it equals the feature index in
            // the same cycle the counter does
            if (state_nxt == ST_L2_FEED)
                l2_addr <= (state == ST_L2_FEED) ? feat_cnt + 1'b1 : '0;
            else if (state_nxt == ST_L2_DRAIN || state_nxt == ST_RESULT)
                l2_addr <= HID_AW'(NUM_HIDDEN - 1);
            else
                l2_addr <= '0;

            if (state == ST_L2_DRAIN && drn_tc)
                result_digit <= digit_in;
        end
    end

endmodule
